// File: rtl/rst_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rst_seq_pkg
// Brief    : Shared types, width helpers and parameter-range checks for the
//            reset sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_DONE    = 2'd2
  } rst_seq_state_e;

  // The timer serves both the hold window and the stage gap.
  function automatic int tmr_width(input int hold, input int gap);
    int m;
    m = (hold > gap) ? hold : gap;
    return $clog2(m + 1);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`define RST_SEQ_PARAM_MIN(LBL, VAL, MIN) \
  if ((VAL) < (MIN)) begin : LBL \
    $error("rst_seq: parameter below legal minimum"); \
  end

`default_nettype wire

// File: rtl/rst_seq_timer.sv
`default_nettype none
// ============================================================================
// Module   : rst_seq_timer
// Brief    : Clearable saturating up-counter with compare-to-limit expiry.
// Revision : 1.0 - initial release
// ============================================================================
module rst_seq_timer #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_limit,
  output logic             o_expired
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_count <= '0;
    end else if (r_count != '1) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = (r_count >= i_limit);

endmodule
`default_nettype wire

// File: rtl/rst_seq_gen.sv
`default_nettype none
// ============================================================================
// Module   : rst_seq_gen
// Brief    : Multi-domain reset sequencer: hold all domains, then release them
//            in order; software may re-sequence via sw_req/sw_ack.
//            Optional monitor and assertions: define RST_SEQ_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module rst_seq_gen
  import rst_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = 3,
  parameter int NUM_STAGES  = 2,
  parameter int STAGE_GAP   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sw_req,
  output logic                  sw_ack,
  output logic [NUM_STAGES-1:0] rst_out,
  output logic                  done,
  output logic                  err
);

  `RST_SEQ_PARAM_MIN(g_bad_hold, HOLD_CYCLES, 1)
  `RST_SEQ_PARAM_MIN(g_bad_stages, NUM_STAGES, 1)
  `RST_SEQ_PARAM_MIN(g_bad_gap, STAGE_GAP, 1)

  localparam int c_tw = tmr_width(HOLD_CYCLES, STAGE_GAP);
  localparam int c_sw = idx_width(NUM_STAGES);
  localparam logic [c_tw-1:0] c_hold_lim = c_tw'(HOLD_CYCLES - 1);
  localparam logic [c_tw-1:0] c_gap_lim  = c_tw'(STAGE_GAP - 1);
  localparam logic [c_sw-1:0] c_last     = c_sw'(NUM_STAGES - 1);

  rst_seq_state_e        r_state;
  logic [NUM_STAGES-1:0] r_rst_out;
  logic [c_sw-1:0]       r_stage;
  logic                  r_done;
  logic                  r_sw_ack;
  logic                  w_tmr_clr;
  logic                  w_tmr_exp;
  logic [c_tw-1:0]       w_tmr_lim;

  assign w_tmr_lim = (r_state == ST_HOLD) ? c_hold_lim : c_gap_lim;
  // Idle in DONE so every new sequence starts from zero.
  assign w_tmr_clr = (r_state == ST_DONE) || w_tmr_exp;

  rst_seq_timer #(
    .WIDTH (c_tw)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_tmr_clr),
    .i_limit   (w_tmr_lim),
    .o_expired (w_tmr_exp)
  );

  // Shifting left clears the lowest still-asserted domain, keeping release order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_HOLD;
      r_rst_out <= '1;
      r_stage   <= '0;
      r_done    <= 1'b0;
      r_sw_ack  <= 1'b0;
    end else begin
      r_sw_ack <= 1'b0;
      case (r_state)
        ST_HOLD: begin
          if (w_tmr_exp) begin
            r_rst_out <= r_rst_out << 1;
            r_stage   <= c_sw'(1);
            if (NUM_STAGES == 1) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_RELEASE;
            end
          end
        end
        ST_RELEASE: begin
          if (w_tmr_exp) begin
            r_rst_out <= r_rst_out << 1;
            if (r_stage == c_last) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_stage <= r_stage + 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (sw_req) begin
            r_sw_ack  <= 1'b1;
            r_rst_out <= '1;
            r_done    <= 1'b0;
            r_state   <= ST_HOLD;
          end
        end
        default: r_state <= ST_HOLD;
      endcase
    end
  end

  assign sw_ack  = r_sw_ack;
  assign rst_out = r_rst_out;
  assign done    = r_done;

`ifdef RST_SEQ_CHECK_EN
  logic r_err;
  logic w_order_bad;

  // Watches the port itself so anything overriding the outputs is caught.
  if (NUM_STAGES > 1) begin : g_order
    assign w_order_bad = |(~rst_out[NUM_STAGES-1:1] & rst_out[NUM_STAGES-2:0]);
  end else begin : g_order_na
    assign w_order_bad = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (((r_state == ST_DONE) && (|rst_out) && !r_sw_ack) || w_order_bad) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;

  property p_hold_then_release;
    @(posedge clk) disable iff (rst)
      ($fell(rst) || r_sw_ack) |-> r_rst_out[0] [*HOLD_CYCLES] ##1 !r_rst_out[0];
  endproperty
  a_hold_then_release: assert property (p_hold_then_release);

  property p_done_all_low;
    @(posedge clk) disable iff (rst) r_done |-> (r_rst_out == '0);
  endproperty
  a_done_all_low: assert property (p_done_all_low);
`else
  assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/rst_seq_gen.md
Name: rst_seq_gen

Overview:
- Reset sequencer that drives multi-domain reset outputs.
- After system reset releases, asserts all outputs for exactly HOLD_CYCLES cycles, then releases domains one at a time, STAGE_GAP cycles apart, and keeps them low permanently.
- Re-sequence only on an explicit software request (req/ack handshake).
- Sits at the top of the design, between the board-level reset and each block's reset input.
- Is the generator side of the "reset high for N ticks, then low forever" property that the team's benches check.

Parameters:
- HOLD_CYCLES, 3, cycles all outputs stay high after rst deasserts or after a request; legal range >=1.
- NUM_STAGES, 2, number of reset domains (width of rst_out); legal range >=1.
- STAGE_GAP, 2, cycles between consecutive stage releases; legal range >=1.

Ports:
- clk  input  1  clock
- rst  input  1  reset: synchronous, active-high; clock is clk
- sw_req  input  1  software re-sequence request, level, held until ack
- sw_ack  output  1  one-cycle pulse: request accepted
- rst_out  output  NUM_STAGES  domain resets, active-high; bit 0 releases first
- done  output  1  high while all rst_out bits are low
- err  output  1  sticky sequencing-violation flag (see Optional Feature)

Behaviour:
- All outputs are registered.
- rst sampled high at a posedge: state HOLD, timer=0, rst_out=all ones, done=0, sw_ack=0, err=0 on the next edge. rst has priority over everything, including mid-RELEASE and DONE.
- FSM states: HOLD, RELEASE, DONE.
- HOLD:
  - Timer increments each edge while rst is low.
  - Let E1 be the first edge where rst is sampled low. rst_out[0] goes low at edge E_HOLD_CYCLES, so rst_out[0] is sampled high on exactly HOLD_CYCLES edges after release.
  - At that edge the state moves to RELEASE (or DONE if NUM_STAGES=1) and the timer clears.
- RELEASE:
  - rst_out[k] falls STAGE_GAP edges after rst_out[k-1].
  - Stage index counter runs 1..NUM_STAGES-1.
  - The edge that clears rst_out[NUM_STAGES-1] also sets done=1 and enters DONE.
- DONE:
  - rst_out stays all zeros indefinitely; done=1.
  - sw_req sampled high: sw_ack=1 for one cycle. The same edge sets rst_out=all ones, done=0, state HOLD, timer=0. HOLD timing then proceeds as above, with E1 = the edge after ack.
- sw_req is ignored (no ack) in HOLD and RELEASE; the requester keeps holding it.
- If sw_req stays high after ack, it retriggers on the next DONE; the requester must drop sw_req the cycle after sw_ack.
- rst_out bits are never released out of order. A released bit never re-asserts except via rst or accepted sw_req.
- Timer width: $clog2(max(HOLD_CYCLES,STAGE_GAP)+1). No wrap: the timer saturates and clears on state change.

Optional Feature:
- Macro: RST_SEQ_CHECK_EN.
- Defined:
  - Internal monitor sets err (sticky, cleared only by rst) if, in DONE, any rst_out bit is high without sw_ack in the previous cycle.
  - Also sets err if rst_out[k] is low while rst_out[k-1] is high.
  - Adds concurrent assertions: rst_out[0] high for HOLD_CYCLES edges after rst falls and then low until the next request; done implies rst_out==0.
- Undefined: err tied to 0; no assertions compiled.

Decomposition:
- Package rst_seq_pkg:
  - state enum typedef (HOLD, RELEASE, DONE);
  - localparam function for the timer width;
  - parameter-range check macros.
- One sub-module, rst_seq_timer: clearable up-counter with a compare-to-limit expiry flag. Instantiated once and shared by HOLD and RELEASE, with the limit muxed by state.

Test Plan:
- Defaults, rst high for 5 edges then low at edge E0: rst_out=11 at E1,E2; 10 at E3; 00 with done=1 at E5; remains 00 through 100 cycles; err=0.
- rst reasserted during RELEASE (after rst_out=10): next edge rst_out=11, done=0; after release the full sequence repeats with identical timing.
- In DONE, pulse sw_req until ack: sw_ack high exactly 1 cycle; rst_out=11 same edge; rst_out[0] low 3 edges later; done 2 edges after that.
- sw_req held high during HOLD: no sw_ack until DONE is reached, then ack and restart; sequence unchanged.
- HOLD_CYCLES=1, NUM_STAGES=1: rst_out falls at E1 and done=1 at E1.
- HOLD_CYCLES=8, NUM_STAGES=4, STAGE_GAP=3: releases at E8,E11,E14,E17.
- With RST_SEQ_CHECK_EN, force rst_out[1] high in DONE: err=1 next cycle and sticky until rst.
